// File: rtl/axi_pkg.sv
// Shared AXI definitions for the AXI4-Lite command master and its neighbours.
//   resp_e          : AXI response codes carried on bresp/rresp
//   master_state_e  : state encoding of the command-to-AXI master FSM
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } master_state_e;

endpackage

// File: rtl/axi4_lite_master_cmd.sv
// Turns a valid/ready command port into single AXI4-Lite master transactions,
// one outstanding at a time, and returns the outcome on a valid/ready
// response port.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   cmd_*                 command in: valid/ready, write flag, addr, wdata, wstrb
//   rsp_*                 response out: valid/ready, write echo, rdata, resp
//   m_axi_aw*/w*/b*       AXI4-Lite write channels (master side)
//   m_axi_ar*/r*          AXI4-Lite read channels (master side)
module axi4_lite_master_cmd
  import axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  master_state_e           state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  // A channel counts as finished if it completed earlier or completes now,
  // so AW and W may finish in either order or in the same cycle.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // Address and data come straight from the command registers, which only
  // change in IDLE, so they are stable for the whole life of each valid.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            state        <= RSP;
          end
        end

        RD: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Directed bench for axi4_lite_master_cmd with a small behavioural
// AXI4-Lite slave (16-word memory, programmable AW/W ready delays and
// programmable bresp/rresp) and a channel monitor.
module tb_axi4_lite_master_cmd;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 aclk = ~aclk;

  axi4_lite_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Slave knobs, set by the stimulus process between transactions.
  int         aw_delay = 0;
  int         w_delay = 0;
  logic [1:0] cfg_bresp = OKAY;
  logic [1:0] cfg_rresp = OKAY;

  int          aw_wait, w_wait;
  logic        got_aw, got_w;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] mem [16];

  logic        aw_hs, w_hs;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  // Ready rises once the valid has waited the programmed number of cycles.
  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_delay);
  assign m_axi_arready = m_axi_arvalid;
  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign wr_addr = aw_hs ? m_axi_awaddr : aw_addr_q;
  assign wr_data = w_hs ? m_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? m_axi_wstrb : w_strb_q;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait      <= 0;
      w_wait       <= 0;
      got_aw       <= 1'b0;
      got_w        <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rresp  <= 2'b00;
      m_axi_rdata  <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      if (aw_hs) begin
        got_aw    <= 1'b1;
        aw_addr_q <= m_axi_awaddr;
      end
      if (w_hs) begin
        got_w    <= 1'b1;
        w_data_q <= m_axi_wdata;
        w_strb_q <= m_axi_wstrb;
      end
      if ((got_aw || aw_hs) && (got_w || w_hs) && !m_axi_bvalid) begin
        got_aw       <= 1'b0;
        got_w        <= 1'b0;
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= cfg_bresp;
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end else if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[m_axi_araddr[5:2]];
        m_axi_rresp  <= cfg_rresp;
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  // Channel monitor: handshake counts, handshake cycle stamps and checks that
  // a pending awvalid neither drops nor changes address before its handshake.
  int          cyc = 0;
  int          n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;
  int          n_aw_stall = 0, n_w_valid = 0, n_aw_drop = 0, n_aw_unstable = 0;
  logic        aw_pend = 1'b0;
  logic [31:0] aw_last = '0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (aw_hs) begin
      n_aw_hs   <= n_aw_hs + 1;
      aw_hs_cyc <= cyc;
    end
    if (w_hs) begin
      n_w_hs   <= n_w_hs + 1;
      w_hs_cyc <= cyc;
    end
    if (m_axi_bvalid && m_axi_bready) n_b_hs <= n_b_hs + 1;
    if (m_axi_awvalid && !m_axi_awready) n_aw_stall <= n_aw_stall + 1;
    if (m_axi_wvalid) n_w_valid <= n_w_valid + 1;
    if (aw_pend && aresetn) begin
      if (!m_axi_awvalid) n_aw_drop <= n_aw_drop + 1;
      else if (m_axi_awaddr != aw_last) n_aw_unstable <= n_aw_unstable + 1;
    end
    aw_pend <= m_axi_awvalid && !m_axi_awready && aresetn;
    aw_last <= m_axi_awaddr;
  end

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called just after a falling edge. Offers one command, waits for it to be
  // accepted and for rsp_valid; lat counts cycles from the accept cycle.
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                output int lat, output logic [31:0] rdata,
                                output logic [1:0] resp, output logic rwr);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check_output("cmd_ready_seen", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge aclk);
      lat++;
    end
    check_output("rsp_valid_seen", rsp_valid, 1);
    rdata = rsp_rdata;
    resp  = rsp_resp;
    rwr   = rsp_write;
  endtask

  int          lat;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        rwr;
  int          s_aw, s_w, s_b, s_stall, s_wv, s_drop, s_unst;
  logic        saw_rsp;

  initial begin
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    check_output("reset_cmd_ready", cmd_ready, 1);
    check_output("reset_awvalid", m_axi_awvalid, 0);
    check_output("reset_wvalid", m_axi_wvalid, 0);
    check_output("reset_arvalid", m_axi_arvalid, 0);
    check_output("reset_bready", m_axi_bready, 0);
    check_output("reset_rready", m_axi_rready, 0);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_awaddr", m_axi_awaddr, 0);
    check_output("awprot", m_axi_awprot, 3'b000);

    // Zero-wait write: AW and W handshake together, response 3 cycles after accept.
    s_aw = n_aw_hs;
    s_w  = n_w_hs;
    apply_stimulus(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, lat, rdata, resp, rwr);
    check_output("wr_latency", lat, 3);
    check_output("wr_resp", resp, OKAY);
    check_output("wr_rsp_write", rwr, 1);
    check_output("wr_rdata_zero", rdata, 0);
    check_output("wr_aw_count", n_aw_hs - s_aw, 1);
    check_output("wr_w_count", n_w_hs - s_w, 1);
    check_output("wr_aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);

    // Read back the same word.
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("rd_latency", lat, 3);
    check_output("rd_rdata", rdata, 32'hDEAD_BEEF);
    check_output("rd_resp", resp, OKAY);
    check_output("rd_rsp_write", rwr, 0);

    // awready 4 cycles late, W immediate, partial strobes.
    aw_delay = 4;
    s_b = n_b_hs; s_stall = n_aw_stall; s_wv = n_w_valid;
    s_drop = n_aw_drop; s_unst = n_aw_unstable;
    apply_stimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, lat, rdata, resp, rwr);
    check_output("awdly_stall_cycles", n_aw_stall - s_stall, 4);
    check_output("awdly_wvalid_cycles", n_w_valid - s_wv, 1);
    check_output("awdly_b_count", n_b_hs - s_b, 1);
    check_output("awdly_aw_dropped", n_aw_drop - s_drop, 0);
    check_output("awdly_aw_unstable", n_aw_unstable - s_unst, 0);
    check_output("awdly_resp", resp, OKAY);
    aw_delay = 0;
    apply_stimulus(1'b0, 32'h0000_0008, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("strb_rdata", rdata, 32'h0000_5678);

    // wready late, slave returns SLVERR on B.
    w_delay = 2;
    cfg_bresp = SLVERR;
    apply_stimulus(1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'hF, lat, rdata, resp, rwr);
    check_output("bresp_slverr", resp, SLVERR);
    check_output("bresp_rsp_write", rwr, 1);
    w_delay = 0;
    cfg_bresp = OKAY;

    // Slave returns SLVERR on R; data still passed through.
    cfg_rresp = SLVERR;
    apply_stimulus(1'b0, 32'h0000_000C, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("rresp_slverr", resp, SLVERR);
    check_output("rresp_rdata", rdata, 32'hA5A5_A5A5);
    cfg_rresp = DECERR;
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("rresp_decerr", resp, DECERR);
    cfg_rresp = OKAY;

    // Response back-pressure: fields held stable, no new command accepted.
    @(negedge aclk);
    rsp_ready = 1'b0;
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rdata, resp, rwr);
    for (int i = 0; i < 5; i++) begin
      check_output("hold_rsp_valid", rsp_valid, 1);
      check_output("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_output("hold_cmd_ready", cmd_ready, 0);
      @(negedge aclk);
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    check_output("release_rsp_valid", rsp_valid, 0);
    check_output("release_cmd_ready", cmd_ready, 1);
    apply_stimulus(1'b0, 32'h0000_0008, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("after_hold_latency", lat, 3);
    check_output("after_hold_rdata", rdata, 32'h0000_5678);

    // Reset while awvalid is pending: valids drop at once, no response later.
    @(negedge aclk);
    aw_delay  = 20;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0010;
    cmd_wdata = 32'h0BAD_F00D;
    cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 1'b0;
    @(negedge aclk);
    check_output("pre_reset_awvalid", m_axi_awvalid, 1);
    aresetn = 1'b0;
    #1;
    check_output("async_awvalid", m_axi_awvalid, 0);
    check_output("async_wvalid", m_axi_wvalid, 0);
    check_output("async_arvalid", m_axi_arvalid, 0);
    check_output("async_bready", m_axi_bready, 0);
    aw_delay = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge aclk);
      if (rsp_valid || m_axi_awvalid) saw_rsp = 1'b1;
    end
    check_output("post_reset_no_activity", saw_rsp, 0);
    check_output("post_reset_cmd_ready", cmd_ready, 1);
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rdata, resp, rwr);
    check_output("post_reset_rd_latency", lat, 3);
    check_output("post_reset_rd_rdata", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
